// File: rtl/dcache_writeback_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dcache_writeback_serializer: drains one dirty cache line to memory word by word
// Rev 1.0
// ----------------------------------------------------------------------------
module dcache_writeback_serializer #(
    parameter int LINE_WIDTH = 128,
    parameter int XLEN       = 32,
    parameter int PLEN       = 34
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_valid_i,
    output logic                  wb_ready_o,
    input  logic [LINE_WIDTH-1:0] wb_data_i,
    input  logic [PLEN-1:0]       wb_addr_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_ack_i,
    output logic [PLEN-1:0]       mem_addr_o,
    output logic [XLEN-1:0]       mem_data_o,
    output logic [2:0]            mem_size_o,
    input  logic [PLEN-1:0]       lookup_addr_i,
    output logic                  lookup_hit_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int NUM_WORDS    = LINE_WIDTH / XLEN;
    localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W        = $clog2(NUM_WORDS);
    localparam int BYTE_SHIFT   = $clog2(XLEN / 8);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [PLEN-1:0] c_line_mask =
        {{(PLEN-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [LINE_WIDTH-1:0] r_buf;
    logic [PLEN-1:0]       r_addr;
    logic                  r_done;
    logic                  w_capture;
    logic                  w_complete;
    logic [XLEN-1:0]       w_word;

    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            IDLE: begin
                if (wb_valid_i) begin
                    w_capture = 1'b1;
                    w_next    = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (mem_ack_i) w_complete = 1'b1;
                    else           w_next     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (mem_ack_i) w_complete = 1'b1;
            end
            default: w_next = IDLE;
        endcase
        if (w_complete) begin
            w_next = (r_cnt == LAST_WORD) ? IDLE : REQ;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_complete && (r_cnt == LAST_WORD);
            if (w_capture) begin
                r_buf  <= wb_data_i;
                r_addr <= wb_addr_i & c_line_mask;
                r_cnt  <= '0;
            end else if (w_complete && (r_cnt != LAST_WORD)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (r_cnt == CNT_W'(k)) w_word = r_buf[k*XLEN +: XLEN];
        end
    end

    assign wb_ready_o   = (r_state == IDLE);
    assign mem_req_o    = (r_state == REQ);
    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done;
    assign mem_size_o   = 3'b010;
    // Payload is only driven while a request is up so the bus idles at zero.
    assign mem_addr_o   = mem_req_o ? (r_addr + PLEN'({r_cnt, {BYTE_SHIFT{1'b0}}})) : '0;
    assign mem_data_o   = mem_req_o ? w_word : '0;
    assign lookup_hit_o = busy_o && (((lookup_addr_i ^ r_addr) & c_line_mask) == '0);

endmodule
`default_nettype wire

// File: doc/dcache_writeback_serializer.md
Name: dcache_writeback_serializer

Overview:
- Downstream stage of the direct-mapped data cache controller.
- Accepts one evicted dirty 128-bit cache line plus its physical address from the cache FSM's writeback buffer.
- Drains the line to main memory as NUM_WORDS sequential XLEN-wide write requests, one outstanding at a time.
- Flags line-address matches so the cache can stall loads/stores that target a line still being drained.

Parameters:
- LINE_WIDTH, 128, cache block width in bits.
- XLEN, 32, memory write word width in bits.
- PLEN, 34, physical address width.
- NUM_WORDS, LINE_WIDTH/XLEN (4), words per line; derived, not overridable.
- OFFSET_WIDTH, $clog2(LINE_WIDTH/8) (4), line byte-offset bits; derived.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wb_valid_i  in  1  writeback line offered.
- wb_ready_o  out  1  serializer can accept a line.
- wb_data_i  in  LINE_WIDTH  dirty line data; word k = bits [k*XLEN +: XLEN].
- wb_addr_i  in  PLEN  line physical address; low OFFSET_WIDTH bits ignored.
- mem_req_o  out  1  write request to memory.
- mem_gnt_i  in  1  memory accepted request.
- mem_ack_i  in  1  memory write completed.
- mem_addr_o  out  PLEN  word-aligned write address.
- mem_data_o  out  XLEN  write data.
- mem_size_o  out  3  constant 3'b010 (four bytes).
- lookup_addr_i  in  PLEN  CPU request address to check.
- lookup_hit_o  out  1  lookup_addr_i is in the line being drained.
- busy_o  out  1  line held (state != IDLE).
- done_o  out  1  one-cycle pulse after the final word is acknowledged.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, word counter=0, line buffer and address cleared.
- Reset outputs: wb_ready_o=1, mem_req_o=0, busy_o=0, done_o=0, lookup_hit_o=0, mem_addr_o=0, mem_data_o=0.
- Reset mid-drain abandons the line silently; no partial-completion indication is given.
- States and transitions:
  - IDLE: wb_ready_o=1. On wb_valid_i, capture data, capture address with low OFFSET_WIDTH bits forced to 0, set cnt=0, go to REQ (next cycle).
  - REQ: mem_req_o=1. mem_addr_o = line_addr + cnt*(XLEN/8). mem_data_o = buffer[cnt*XLEN +: XLEN]. Request and payload are held stable until mem_gnt_i.
    - On gnt with ack in the same cycle: treat the word as complete (see completion below).
    - On gnt without ack: go to WAIT_ACK.
  - WAIT_ACK: mem_req_o=0. Wait for mem_ack_i.
- Word completion (ack in WAIT_ACK, or gnt+ack in REQ):
  - If cnt==NUM_WORDS-1: go to IDLE and register done_o=1 for exactly the next cycle.
  - Otherwise: increment cnt and go to REQ.
- mem_ack_i outside WAIT_ACK is ignored, except when it accompanies gnt in REQ.
- mem_gnt_i outside REQ is ignored.
- Minimum latency: line accepted at cycle 0, with gnt+ack each cycle, gives mem_req_o high in cycles 1-4 and done_o high in cycle 5.
- done_o and wb_ready_o=1 coincide. A new line offered in that cycle is accepted, so back-to-back drains are permitted.
- cnt is $clog2(NUM_WORDS) bits wide. It never wraps during a drain because it resets to 0 on capture.
- Address arithmetic is performed at PLEN width. The line is aligned, so no carry out of the offset field occurs.
- lookup_hit_o is combinational: busy_o && (lookup_addr_i[PLEN-1:OFFSET_WIDTH] == line_addr[PLEN-1:OFFSET_WIDTH]). It is low in IDLE, including the capture cycle.
- Captured data is immune to later changes on wb_data_i/wb_addr_i, so the cache may overwrite the evicted line immediately after the handshake.

Test Plan:
- Basic drain: line 0x44443333_22221111_DDDDCCCC_BBBBAAAA at 0x0_8000_0010, gnt+ack every cycle. Required writes: 0x80000010=0xBBBBAAAA, 0x80000014=0xDDDDCCCC, 0x80000018=0x22221111, 0x8000001C=0x44443333. done_o pulses at cycle 5.
- Unaligned input address 0x0_8000_001A with gnt delayed 3 cycles per word: first mem_addr_o=0x80000010. Address and data stay stable while mem_req_o=1 and gnt=0. All 4 words are issued in order.
- Split gnt/ack: gnt at cycle 1, ack at cycle 4. mem_req_o drops after gnt, the next request does not start until cycle 5, and a stray ack in REQ without gnt is ignored.
- Lookup: during drain of 0x80000010, lookup 0x8000001C gives hit=1 and lookup 0x80000020 gives hit=0. After done_o, lookup 0x8000001C gives hit=0.
- Back-to-back: second line offered during the done_o cycle is accepted; its first request appears on the next cycle with no idle gap.
- Reset after word 2 is granted: all outputs return to reset values asynchronously. A new line after reset starts at word 0.
